// File: rtl/ddr_init_seq.sv
// DDR4 power-up sequencer: reset_n/CKE timing, MR3..MR0 + ZQCL per rank over a
// valid/ready command port, plus a timing-only MR4/MR2/MR1/MR0 refresh path.
module ddr_init_seq #(
  parameter int unsigned NUM_RANKS = 1,
  parameter int unsigned RESET_CYC = 20,
  parameter int unsigned CKE_CYC   = 50,
  parameter int unsigned TXPR      = 24,
  parameter int unsigned TMRD      = 8,
  parameter int unsigned TMOD      = 24,
  parameter int unsigned TZQINIT   = 1024
) (
  input  logic        clock_t,
  input  logic        reset,
  input  logic        start,
  input  logic        cfg_update,
  input  logic [1:0]  burst_length,
  input  logic [1:0]  al_dly,
  input  logic [4:0]  cas_dly,
  input  logic [4:0]  wr_dly,
  input  logic        w_pre,
  input  logic        r_pre,
  input  logic        cmd_ready,
  output logic        ddr_reset_n,
  output logic        cke,
  output logic        cmd_valid,
  output logic [1:0]  cmd_type,
  output logic [1:0]  cmd_rank,
  output logic [2:0]  mr_sel,
  output logic [17:0] mr_data,
  output logic        busy,
  output logic        init_done
);

  typedef enum logic [3:0] {
    IDLE, RST_ASSERT, RST_RELEASE, XPR, MRS_ISSUE, MRS_WAIT, MOD_WAIT,
    ZQ_ISSUE, ZQ_WAIT, DONE, UPD_ISSUE, UPD_WAIT, UPD_MOD
  } state_t;

  typedef struct packed {
    logic [1:0] bl;
    logic [1:0] al;
    logic [4:0] cas;
    logic [4:0] wr;
    logic       w_pre;
    logic       r_pre;
  } cfg_t;

  localparam logic [1:0] CMD_NOP  = 2'd0;
  localparam logic [1:0] CMD_MRS  = 2'd1;
  localparam logic [1:0] CMD_ZQCL = 2'd2;

  localparam logic [2:0] LAST_IDX  = 3'd6;
  // MR4, MR2, MR1, MR0 are the tail of the full MR order, so updates start here
  localparam logic [2:0] UPD_FIRST = 3'd3;
  localparam logic [1:0] LAST_RANK = 2'(NUM_RANKS - 1);

  function automatic logic [31:0] wait_load(input int unsigned n);
    return (n == 0) ? '0 : 32'(n - 1);
  endfunction

  localparam logic [31:0] W_RESET = wait_load(RESET_CYC);
  localparam logic [31:0] W_CKE   = wait_load(CKE_CYC);
  localparam logic [31:0] W_XPR   = wait_load(TXPR);
  localparam logic [31:0] W_MRD   = wait_load(TMRD);
  localparam logic [31:0] W_MOD   = wait_load(TMOD);
  localparam logic [31:0] W_ZQ    = wait_load(TZQINIT);

  function automatic logic [2:0] mr_sel_of(input logic [2:0] idx);
    case (idx)
      3'd0:    return 3'd3;
      3'd1:    return 3'd6;
      3'd2:    return 3'd5;
      3'd3:    return 3'd4;
      3'd4:    return 3'd2;
      3'd5:    return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [17:0] mr_data_of(input logic [2:0] idx, input cfg_t c);
    logic [17:0] v;
    v = '0;
    case (mr_sel_of(idx))
      3'd0: begin
        v[1:0] = c.bl;
        v[8:4] = c.cas;
      end
      3'd1: begin
        v[0]   = 1'b1;
        v[4:3] = c.al;
      end
      3'd2: v[7:3] = c.wr;
      3'd4: begin
        v[11] = c.r_pre;
        v[12] = c.w_pre;
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t      state;
  cfg_t        cfg;
  cfg_t        cfg_in;
  logic [31:0] cnt;
  logic [2:0]  idx;
  logic        wait_done;

  assign cfg_in    = '{bl: burst_length, al: al_dly, cas: cas_dly, wr: wr_dly,
                       w_pre: w_pre, r_pre: r_pre};
  assign wait_done = (cnt == '0);

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cfg         <= '0;
      cnt         <= '0;
      idx         <= '0;
      ddr_reset_n <= 1'b0;
      cke         <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_type    <= CMD_NOP;
      cmd_rank    <= '0;
      mr_sel      <= '0;
      mr_data     <= '0;
      busy        <= 1'b0;
      init_done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RST_ASSERT;
            cnt         <= W_RESET;
            cfg         <= cfg_in;
            ddr_reset_n <= 1'b0;
            cke         <= 1'b0;
            busy        <= 1'b1;
            init_done   <= 1'b0;
          end else if (cfg_update && state == DONE) begin
            state     <= UPD_ISSUE;
            cfg       <= cfg_in;
            idx       <= UPD_FIRST;
            busy      <= 1'b1;
            cmd_valid <= 1'b1;
            cmd_type  <= CMD_MRS;
            cmd_rank  <= '0;
            mr_sel    <= mr_sel_of(UPD_FIRST);
            mr_data   <= mr_data_of(UPD_FIRST, cfg_in);
          end
        end

        RST_ASSERT: begin
          if (wait_done) begin
            state       <= RST_RELEASE;
            cnt         <= W_CKE;
            ddr_reset_n <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        RST_RELEASE: begin
          if (wait_done) begin
            state <= XPR;
            cnt   <= W_XPR;
            cke   <= 1'b1;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        XPR: begin
          if (wait_done) begin
            state     <= MRS_ISSUE;
            idx       <= '0;
            cmd_valid <= 1'b1;
            cmd_type  <= CMD_MRS;
            cmd_rank  <= '0;
            mr_sel    <= mr_sel_of(3'd0);
            mr_data   <= mr_data_of(3'd0, cfg);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        MRS_ISSUE, UPD_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            if (idx == LAST_IDX) begin
              state <= (state == MRS_ISSUE) ? MOD_WAIT : UPD_MOD;
              cnt   <= W_MOD;
            end else begin
              state <= (state == MRS_ISSUE) ? MRS_WAIT : UPD_WAIT;
              cnt   <= W_MRD;
              idx   <= idx + 3'd1;
            end
          end
        end

        MRS_WAIT, UPD_WAIT: begin
          if (wait_done) begin
            state     <= (state == MRS_WAIT) ? MRS_ISSUE : UPD_ISSUE;
            cmd_valid <= 1'b1;
            cmd_type  <= CMD_MRS;
            mr_sel    <= mr_sel_of(idx);
            mr_data   <= mr_data_of(idx, cfg);
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        MOD_WAIT: begin
          if (wait_done) begin
            state     <= ZQ_ISSUE;
            cmd_valid <= 1'b1;
            cmd_type  <= CMD_ZQCL;
            mr_sel    <= '0;
            mr_data   <= '0;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        ZQ_ISSUE: begin
          if (cmd_ready) begin
            state     <= ZQ_WAIT;
            cnt       <= W_ZQ;
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
          end
        end

        ZQ_WAIT, UPD_MOD: begin
          if (wait_done) begin
            if (cmd_rank != LAST_RANK) begin
              state     <= (state == ZQ_WAIT) ? MRS_ISSUE : UPD_ISSUE;
              idx       <= (state == ZQ_WAIT) ? 3'd0 : UPD_FIRST;
              cmd_rank  <= cmd_rank + 2'd1;
              cmd_valid <= 1'b1;
              cmd_type  <= CMD_MRS;
              mr_sel    <= mr_sel_of((state == ZQ_WAIT) ? 3'd0 : UPD_FIRST);
              mr_data   <= mr_data_of((state == ZQ_WAIT) ? 3'd0 : UPD_FIRST, cfg);
            end else begin
              state     <= DONE;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: default single-rank instance plus a
// two-rank instance with short timings (TMRD=0 exercises the zero-as-one rule).
module tb_ddr_init_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        cfg_update = 1'b0;
  logic        upd2 = 1'b0;
  logic [1:0]  burst_length = 2'b10;
  logic [1:0]  al_dly = 2'd0;
  logic [4:0]  cas_dly = 5'd4;
  logic [4:0]  wr_dly = 5'd10;
  logic        w_pre = 1'b1;
  logic        r_pre = 1'b1;
  logic        cmd_ready = 1'b1;

  logic        ddr_reset_n, cke, cmd_valid, busy, init_done;
  logic [1:0]  cmd_type, cmd_rank;
  logic [2:0]  mr_sel;
  logic [17:0] mr_data;

  logic        ddr_reset_n2, cke2, cmd_valid2, busy2, init_done2;
  logic [1:0]  cmd_type2, cmd_rank2;
  logic [2:0]  mr_sel2;
  logic [17:0] mr_data2;

  int errors = 0;
  int checks = 0;
  int t = 0;

  always #5 clk = ~clk;

  ddr_init_seq u1 (
    .clock_t(clk), .reset(reset), .start(start), .cfg_update(cfg_update),
    .burst_length(burst_length), .al_dly(al_dly), .cas_dly(cas_dly), .wr_dly(wr_dly),
    .w_pre(w_pre), .r_pre(r_pre), .cmd_ready(cmd_ready),
    .ddr_reset_n(ddr_reset_n), .cke(cke), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_rank(cmd_rank), .mr_sel(mr_sel), .mr_data(mr_data), .busy(busy),
    .init_done(init_done)
  );

  ddr_init_seq #(
    .NUM_RANKS(2), .RESET_CYC(3), .CKE_CYC(4), .TXPR(2),
    .TMRD(0), .TMOD(5), .TZQINIT(10)
  ) u2 (
    .clock_t(clk), .reset(reset), .start(start2), .cfg_update(upd2),
    .burst_length(burst_length), .al_dly(al_dly), .cas_dly(cas_dly), .wr_dly(wr_dly),
    .w_pre(w_pre), .r_pre(r_pre), .cmd_ready(cmd_ready),
    .ddr_reset_n(ddr_reset_n2), .cke(cke2), .cmd_valid(cmd_valid2), .cmd_type(cmd_type2),
    .cmd_rank(cmd_rank2), .mr_sel(mr_sel2), .mr_data(mr_data2), .busy(busy2),
    .init_done(init_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s @cyc %0d: got %0h expected %0h", tag, t, got, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  task automatic at(input int target);
    if (target > t) tick(target - t);
  endtask

  logic [2:0]  exp_sel  [7] = '{3'd3, 3'd6, 3'd5, 3'd4, 3'd2, 3'd1, 3'd0};
  logic [17:0] exp_data [7] = '{18'h0, 18'h0, 18'h0, 18'h01800, 18'h00050, 18'h00001, 18'h00042};
  logic [2:0]  upd_sel  [4] = '{3'd4, 3'd2, 3'd1, 3'd0};
  logic [17:0] upd_data [4] = '{18'h01800, 18'h00050, 18'h00001, 18'h00062};

  initial begin
    int e0, e1, e2, f0, x, y1, z, w1;

    // Reset state
    tick(3);
    chk("rst_reset_n", 32'(ddr_reset_n), 0);
    chk("rst_cke", 32'(cke), 0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_mr_data", 32'(mr_data), 0);
    reset = 1'b0;

    // Full init with defaults, cmd_ready high except the MR6 stall
    at(10);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e0 = t;
    cas_dly = 5'd9;
    chk("start_busy", 32'(busy), 1);
    chk("start_reset_n", 32'(ddr_reset_n), 0);
    at(e0 + 19); chk("reset_n_low_19", 32'(ddr_reset_n), 0);
    at(e0 + 20); chk("reset_n_high_20", 32'(ddr_reset_n), 1);
    chk("cke_low_at_release", 32'(cke), 0);
    at(e0 + 69); chk("cke_low_69", 32'(cke), 0);
    at(e0 + 70); chk("cke_high_70", 32'(cke), 1);
    at(e0 + 93); chk("no_mrs_before_txpr", 32'(cmd_valid), 0);

    x = e0 + 94;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) begin
        at(x - 1);
        chk("mrs_gap_idle", 32'(cmd_valid), 0);
      end
      at(x);
      chk("mrs_valid", 32'(cmd_valid), 1);
      chk("mrs_type", 32'(cmd_type), 1);
      chk("mrs_sel", 32'(mr_sel), 32'(exp_sel[k]));
      chk("mrs_data", 32'(mr_data), 32'(exp_data[k]));
      chk("mrs_rank", 32'(cmd_rank), 0);
      if (k == 1) begin
        cmd_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick(1);
          chk("stall_valid", 32'(cmd_valid), 1);
          chk("stall_sel", 32'(mr_sel), 6);
        end
        cmd_ready = 1'b1;
      end
      tick(1);
      chk("mrs_done_valid", 32'(cmd_valid), 0);
      chk("mrs_done_type", 32'(cmd_type), 0);
      x = t + 8;
    end

    y1 = t;
    at(y1 + 23); chk("no_zq_before_tmod", 32'(cmd_valid), 0);
    at(y1 + 24);
    chk("zq_valid", 32'(cmd_valid), 1);
    chk("zq_type", 32'(cmd_type), 2);
    chk("zq_sel", 32'(mr_sel), 0);
    chk("zq_data", 32'(mr_data), 0);
    z = t;
    tick(1);
    chk("zq_done_valid", 32'(cmd_valid), 0);
    at(z + 1024);
    chk("init_low_1023", 32'(init_done), 0);
    chk("busy_during_zq", 32'(busy), 1);
    at(z + 1025);
    chk("init_done_high", 32'(init_done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_cke", 32'(cke), 1);
    chk("done_reset_n", 32'(ddr_reset_n), 1);

    // Runtime re-program with cas_dly = 6
    cas_dly = 5'd6;
    cfg_update = 1'b1;
    tick(1);
    cfg_update = 1'b0;
    cas_dly = 5'd7;
    x = t;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        at(x - 1);
        chk("upd_gap_idle", 32'(cmd_valid), 0);
      end
      at(x);
      chk("upd_valid", 32'(cmd_valid), 1);
      chk("upd_type", 32'(cmd_type), 1);
      chk("upd_sel", 32'(mr_sel), 32'(upd_sel[k]));
      chk("upd_data", 32'(mr_data), 32'(upd_data[k]));
      chk("upd_init_done", 32'(init_done), 1);
      chk("upd_busy", 32'(busy), 1);
      chk("upd_reset_n", 32'(ddr_reset_n), 1);
      tick(1);
      chk("upd_done_valid", 32'(cmd_valid), 0);
      x = t + 8;
    end
    w1 = t;
    at(w1 + 23);
    chk("upd_tmod_busy", 32'(busy), 1);
    chk("upd_tmod_valid", 32'(cmd_valid), 0);
    at(w1 + 24);
    chk("upd_back_done_busy", 32'(busy), 0);
    chk("upd_no_zq", 32'(cmd_valid), 0);
    chk("upd_back_init", 32'(init_done), 1);

    // start and cfg_update together: start wins
    start = 1'b1;
    cfg_update = 1'b1;
    tick(1);
    start = 1'b0;
    cfg_update = 1'b0;
    e1 = t;
    chk("both_reset_n", 32'(ddr_reset_n), 0);
    chk("both_cke", 32'(cke), 0);
    chk("both_init_done", 32'(init_done), 0);
    chk("both_busy", 32'(busy), 1);
    chk("both_valid", 32'(cmd_valid), 0);

    // Async reset in MRS_WAIT
    at(e1 + 94);
    chk("reinit_first_mrs", 32'(mr_sel), 3);
    at(e1 + 97);
    chk("in_mrs_wait", 32'(cmd_valid), 0);
    reset = 1'b1;
    #1;
    chk("async_reset_n", 32'(ddr_reset_n), 0);
    chk("async_cke", 32'(cke), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_sel", 32'(mr_sel), 0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk("idle_after_reset", 32'(busy), 0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    e2 = t;
    chk("replay_busy", 32'(busy), 1);
    at(e2 + 19); chk("replay_reset_n_19", 32'(ddr_reset_n), 0);
    at(e2 + 20); chk("replay_reset_n_20", 32'(ddr_reset_n), 1);
    at(e2 + 94);
    chk("replay_mrs_valid", 32'(cmd_valid), 1);
    chk("replay_mrs_sel", 32'(mr_sel), 3);

    // Two-rank instance, short timings
    burst_length = 2'b01;
    cas_dly = 5'd12;
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    f0 = t;
    at(f0 + 2);  chk("r2_reset_n_low", 32'(ddr_reset_n2), 0);
    at(f0 + 3);  chk("r2_reset_n_high", 32'(ddr_reset_n2), 1);
    at(f0 + 6);  chk("r2_cke_low", 32'(cke2), 0);
    at(f0 + 7);  chk("r2_cke_high", 32'(cke2), 1);
    at(f0 + 8);  chk("r2_no_mrs", 32'(cmd_valid2), 0);
    at(f0 + 9);
    chk("r2_mr3_valid", 32'(cmd_valid2), 1);
    chk("r2_mr3_sel", 32'(mr_sel2), 3);
    chk("r2_mr3_rank", 32'(cmd_rank2), 0);
    at(f0 + 10); chk("r2_tmrd0_gap", 32'(cmd_valid2), 0);
    at(f0 + 11);
    chk("r2_mr6_valid", 32'(cmd_valid2), 1);
    chk("r2_mr6_sel", 32'(mr_sel2), 6);
    at(f0 + 27);
    chk("r2_zq0_type", 32'(cmd_type2), 2);
    chk("r2_zq0_rank", 32'(cmd_rank2), 0);
    at(f0 + 37);
    chk("r2_rank0_wait", 32'(cmd_valid2), 0);
    chk("r2_init_low_mid", 32'(init_done2), 0);
    at(f0 + 38);
    chk("r2_rank1_valid", 32'(cmd_valid2), 1);
    chk("r2_rank1_type", 32'(cmd_type2), 1);
    chk("r2_rank1_rank", 32'(cmd_rank2), 1);
    chk("r2_rank1_sel", 32'(mr_sel2), 3);
    at(f0 + 50);
    chk("r2_rank1_mr0_sel", 32'(mr_sel2), 0);
    chk("r2_rank1_mr0_data", 32'(mr_data2), 32'h000C1);
    at(f0 + 56);
    chk("r2_zq1_type", 32'(cmd_type2), 2);
    chk("r2_zq1_rank", 32'(cmd_rank2), 1);
    at(f0 + 66);
    chk("r2_init_low_end", 32'(init_done2), 0);
    chk("r2_busy_end", 32'(busy2), 1);
    at(f0 + 67);
    chk("r2_init_done", 32'(init_done2), 1);
    chk("r2_idle_busy", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
